// File: rtl/lisp_io_regs.sv
// lisp_io_regs: register-port peripheral for lisp_core.
// LED register, TX FIFO + 8N1 serializer, single-byte RX holding register.
module lisp_io_regs #(
  parameter int CLKS_PER_BIT  = 50,
  parameter int TX_FIFO_DEPTH = 8,
  parameter int LED_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           register_index,
  input  logic                 register_read,
  input  logic                 register_write,
  input  logic [15:0]          register_write_value,
  output logic [15:0]          register_read_value,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 uart_tx,
  input  logic                 uart_rx
);

  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CMAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CHALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_st_t;

  logic sel_tx, sel_led, sel_st, sel_rx;
  assign sel_tx  = register_index == 7'd0;
  assign sel_led = register_index == 7'd1;
  assign sel_st  = register_index == 7'd2;
  assign sel_rx  = register_index == 7'd3;

  logic push_req, st_wr, rx_rd;
  assign push_req = register_write & sel_tx;
  assign st_wr    = register_write & sel_st;
  assign rx_rd    = register_read & sel_rx;

  logic unused_hi;
  assign unused_hi = ^register_write_value[15:8];

  // FIFO
  logic [7:0]  mem [TX_FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign push  = push_req & ~full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= register_write_value[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // TX serializer
  uart_st_t        tx_st;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_bit;
  logic [7:0]      tx_sh;
  logic            tx_busy;

  // Pop from IDLE, or at the end of STOP so frames run back-to-back.
  assign pop = ~empty & ((tx_st == IDLE) |
               ((tx_st == STOP) & (tx_cnt == CMAX)));
  assign tx_busy = (tx_st != IDLE) | ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_st   <= IDLE;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '0;
      uart_tx <= 1'b1;
    end else begin
      unique case (tx_st)
        IDLE: if (pop) begin
          tx_sh   <= mem[rd_ptr[AW-1:0]];
          tx_cnt  <= '0;
          tx_st   <= START;
          uart_tx <= 1'b0;
        end
        START: if (tx_cnt == CMAX) begin
          tx_cnt  <= '0;
          tx_bit  <= '0;
          tx_st   <= DATA;
          uart_tx <= tx_sh[0];
        end else tx_cnt <= tx_cnt + 1'b1;
        DATA: if (tx_cnt == CMAX) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            tx_st   <= STOP;
            uart_tx <= 1'b1;
          end else begin
            tx_bit  <= tx_bit + 1'b1;
            tx_sh   <= {1'b0, tx_sh[7:1]};
            uart_tx <= tx_sh[1];
          end
        end else tx_cnt <= tx_cnt + 1'b1;
        STOP: if (tx_cnt == CMAX) begin
          tx_cnt <= '0;
          if (pop) begin
            tx_sh   <= mem[rd_ptr[AW-1:0]];
            tx_st   <= START;
            uart_tx <= 1'b0;
          end else tx_st <= IDLE;
        end else tx_cnt <= tx_cnt + 1'b1;
        default: tx_st <= IDLE;
      endcase
    end
  end

  // RX deserializer
  logic [1:0]    rx_sync;
  logic          rx_s, rx_prev, rx_done;
  uart_st_t      rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;

  assign rx_s    = rx_sync[1];
  assign rx_done = (rx_st == STOP) & (rx_cnt == CMAX) & rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
      rx_st   <= IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
      unique case (rx_st)
        IDLE: if (rx_prev & ~rx_s) begin
          rx_cnt <= '0;
          rx_st  <= START;
        end
        START: if (rx_cnt == CHALF) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s ? IDLE : DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        DATA: if (rx_cnt == CMAX) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_st <= STOP;
          else rx_bit <= rx_bit + 1'b1;
        end else rx_cnt <= rx_cnt + 1'b1;
        STOP: if (rx_cnt == CMAX) begin
          rx_cnt <= '0;
          rx_st  <= IDLE;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: rx_st <= IDLE;
      endcase
    end
  end

  // Registers and read port
  logic        tx_ovf, rx_orun, rx_valid;
  logic [7:0]  rx_data;
  logic [15:0] led_ext, status, rd_mux;

  always_comb begin
    led_ext = '0;
    led_ext[LED_WIDTH-1:0] = leds;
  end

  assign status = {10'd0, tx_busy, rx_orun, tx_ovf,
                   rx_valid, empty, full};

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_led: rd_mux = led_ext;
      sel_st:  rd_mux = status;
      sel_rx:  rd_mux = {8'h00, rx_data};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      register_read_value <= '0;
      leds     <= '0;
      tx_ovf   <= 1'b0;
      rx_orun  <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      if (register_read) register_read_value <= rd_mux;
      if (register_write & sel_led)
        leds <= register_write_value[LED_WIDTH-1:0];
      if (push_req & full) tx_ovf <= 1'b1;
      else if (st_wr & register_write_value[3]) tx_ovf <= 1'b0;
      // A completing frame wins over a same-edge RX_DATA read.
      if (rx_done) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (rx_rd) rx_valid <= 1'b0;
      if (rx_done & rx_valid & ~rx_rd) rx_orun <= 1'b1;
      else if (st_wr & register_write_value[4]) rx_orun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lisp_io_regs.sv
// tb_lisp_io_regs: random + directed bench for lisp_io_regs.
// Queue-based reference model checked on every falling clock edge.
module tb_lisp_io_regs;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  register_index = '0;
  logic        register_read = 1'b0;
  logic        register_write = 1'b0;
  logic [15:0] register_write_value = '0;
  logic [15:0] register_read_value;
  logic [7:0]  leds;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  lisp_io_regs #(
    .CLKS_PER_BIT(CPB),
    .TX_FIFO_DEPTH(DEPTH),
    .LED_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .register_index(register_index),
    .register_read(register_read),
    .register_write(register_write),
    .register_write_value(register_write_value),
    .register_read_value(register_read_value),
    .leds(leds),
    .uart_tx(uart_tx),
    .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp,
               $time);
    end
  endtask

  // Reference model: byte queue, per-clock line waveform queue.
  bit [7:0]  m_fifo[$];
  bit        m_line[$];
  bit [7:0]  m_leds = 0;
  bit [15:0] m_rv = 0;
  bit        m_ovf = 0, m_orun = 0, m_rxv = 0;
  bit [7:0]  m_rxd = 0;

  always @(posedge clk or negedge reset_n) begin
    bit full_pre, empty_pre, busy_pre;
    bit [7:0] b;
    if (!reset_n) begin
      m_fifo.delete();
      m_line.delete();
      m_leds = 0; m_rv = 0;
      m_ovf = 0; m_orun = 0; m_rxv = 0; m_rxd = 0;
    end else begin
      full_pre  = m_fifo.size() == DEPTH;
      empty_pre = m_fifo.size() == 0;
      busy_pre  = (m_line.size() != 0) || !empty_pre;
      if (register_read) begin
        case (register_index)
          7'd1: m_rv = {8'h00, m_leds};
          7'd2: m_rv = {10'd0, busy_pre, m_orun, m_ovf, m_rxv,
                        empty_pre, full_pre};
          7'd3: m_rv = {8'h00, m_rxd};
          default: m_rv = 0;
        endcase
        if (register_index == 7'd3) m_rxv = 0;
      end
      if (m_line.size() != 0) void'(m_line.pop_front());
      if (m_line.size() == 0 && m_fifo.size() != 0) begin
        b = m_fifo.pop_front();
        for (int i = 0; i < 10; i++)
          repeat (CPB)
            m_line.push_back(i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1]);
      end
      if (register_write) begin
        case (register_index)
          7'd0: if (full_pre) m_ovf = 1;
                else m_fifo.push_back(register_write_value[7:0]);
          7'd1: m_leds = register_write_value[7:0];
          7'd2: begin
            if (register_write_value[3]) m_ovf = 0;
            if (register_write_value[4]) m_orun = 0;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("leds", {8'h00, leds}, {8'h00, m_leds});
      chk("uart_tx", {15'd0, uart_tx},
          {15'd0, m_line.size() != 0 ? m_line[0] : 1'b1});
      chk("read_value", register_read_value, m_rv);
    end
  end

  task automatic drive(input logic rd, input logic wr,
                       input logic [6:0] idx, input logic [15:0] v);
    register_read = rd;
    register_write = wr;
    register_index = idx;
    register_write_value = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask

  task automatic rd_chk(input string nm, input logic [6:0] idx,
                        input logic [15:0] exp);
    drive(1, 0, idx, 0);
    chk(nm, register_read_value, exp);
    drive(0, 0, 0, 0);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      drive(1, 0, 2, 0);
      if (!register_read_value[5]) done = 1;
      drive(0, 0, 0, 0);
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL tx_drain: busy still 1 expected 0");
    end
  endtask

  // Frame delivery lands about one bit after the stop bit starts.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CPB);
    end
    uart_rx = stop;
    idle(CPB);
    uart_rx = 1'b1;
    idle(6);
    if (stop) begin
      if (m_rxv) m_orun = 1;
      m_rxv = 1;
      m_rxd = b;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] fr;
    bit found;
    logic [7:0] rb;
    int r;

    repeat (3) @(posedge clk);
    #1;
    chk_on = 1;
    reset_n = 1'b1;
    chk("reset_leds", {8'h00, leds}, 16'h0000);
    chk("reset_tx", {15'd0, uart_tx}, 16'h0001);
    rd_chk("reset_status", 2, 16'h0002);

    drive(0, 1, 0, 16'h0041);
    found = 0;
    for (int i = 0; i < 20 && !found; i++)
      if (uart_tx == 1'b0) found = 1;
      else idle(1);
    chk("tx_start_seen", {15'd0, found}, 16'h0001);
    idle(2);
    fr[0] = uart_tx;
    for (int j = 1; j < 10; j++) begin
      idle(CPB);
      fr[j] = uart_tx;
    end
    chk("tx_frame_41", {6'd0, fr}, 16'b0000_0010_1000_0010);
    idle(CPB);
    rd_chk("tx_done_status", 2, 16'h0002);

    drive(0, 1, 1, 16'hFFA5);
    chk("leds_a5", {8'h00, leds}, 16'h00A5);
    rd_chk("leds_read", 1, 16'h00A5);

    for (int i = 0; i < 9; i++) drive(0, 1, 0, 16'h0030 + 16'(i));
    rd_chk("fifo_full_no_ovf", 2, 16'h0021);
    for (int i = 0; i < 9; i++) drive(0, 1, 0, 16'h0040 + 16'(i));
    rd_chk("fifo_ovf", 2, 16'h0029);
    drive(0, 1, 2, 16'h0008);
    rd_chk("ovf_cleared", 2, 16'h0021);
    wait_idle();

    idle(2);
    send_rx(8'h5A, 1'b1);
    rd_chk("rx_valid", 2, 16'h0006);
    rd_chk("rx_data_5a", 3, 16'h005A);
    rd_chk("rx_valid_clr", 2, 16'h0002);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd_chk("rx_overrun", 2, 16'h0016);
    rd_chk("rx_data_22", 3, 16'h0022);
    drive(0, 1, 2, 16'h0010);
    rd_chk("orun_cleared", 2, 16'h0002);
    send_rx(8'hC3, 1'b0);
    rd_chk("frame_err", 2, 16'h0002);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      rb = 8'($urandom);
      case (r)
        0: drive(0, 1, 0, {8'($urandom), rb});
        1: drive(0, 1, 1, 16'($urandom));
        2: drive(0, 1, 2, 16'($urandom));
        3: drive(1, 0, 7'($urandom_range(0, 4)), 0);
        4: drive(1, 1, 7'($urandom_range(0, 3)), 16'($urandom));
        5: drive(0, 1, 7'd127, 16'($urandom));
        6: drive(1, 0, 7'd100, 0);
        default: drive(0, 0, 0, 0);
      endcase
      if (n % 100 == 50) begin
        idle(1);
        send_rx(rb, 1'($urandom_range(0, 3) != 0));
      end
    end
    idle(1);
    wait_idle();

    drive(0, 1, 0, 16'h0055);
    idle(15);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_tx", {15'd0, uart_tx}, 16'h0001);
    chk("async_rst_leds", {8'h00, leds}, 16'h0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    chk("post_rst_tx", {15'd0, uart_tx}, 16'h0001);
    rd_chk("post_rst_status", 2, 16'h0002);
    uart_rx = 1'b0;
    idle(1);
    uart_rx = 1'b1;
    idle(20);
    rd_chk("glitch_ignored", 2, 16'h0002);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
